pipeline_minmax_window_core: RTL
================================

# pipeline_minmax_window_core

Pipelined min/max reduction over CNO trigger channels, followed by temporal accumulation over a programmable window of input samples. Each window reports one winner: value, metadata, and source channel, plus the count of contributing samples. The block sits between per-channel trigger feature extraction and the trigger-consolidation decision logic. It succeeds the single-cycle-window min/max core by adding a runtime mode, channel-index output, windowing, and synchronous clear.

## Interface
- D_WIDTH, 26, data value width per channel
- M_WIDTH, 8, metadata width per channel
- CNO, 8, channel count (≥2)
- LATENCY_UNIT, 1, register stages per tree level (≥1)
- W_WIDTH, 8, width of window length and sample count
- CH_W, $clog2(CNO), channel index width
- clk  in  1  clock
- arst  in  1  reset, asynchronous, active-high
- data_array  in  CNO*D_WIDTH  channel i at bits [i*D_WIDTH +: D_WIDTH]
- m_array  in  CNO*M_WIDTH  per-channel metadata, same packing
- valid_array  in  CNO  per-channel valid
- in_strobe  in  1  sample present this cycle
- mode  in  1  1 = min, 0 = max; sampled with in_strobe
- win_len  in  W_WIDTH  samples per window; 0 is treated as 1
- sync_clr  in  1  synchronous discard of all in-flight state
- result  out  D_WIDTH  winning value
- result_m  out  M_WIDTH  winner metadata
- result_ch  out  CH_W  winner channel index
- result_valid  out  1  at least one valid channel in the window
- result_cnt  out  W_WIDTH  number of samples in the window with ≥1 valid channel
- out_strobe  out  1  one-cycle pulse at window close

## Operation
- **Tree.**
  - Binary compare tree of ceil(log2 CNO) levels; odd leftovers pass through the level registered.
  - Each node carries {data, m, ch, valid, strobe, mode}.
  - Node rules:
    - An invalid operand never wins.
    - If both operands are invalid, the node output is invalid with data, m, and ch zeroed.
    - On equal values, the lower channel index wins.
- **Accumulator FSM.**
  - IDLE:
    - On a tree-output strobe, latch win_len (0→1) and that sample's mode.
    - Load the sample as the current best.
    - Set cnt = sample valid.
    - Go to ACCUM, unless the latched length is 1, in which case close immediately.
  - ACCUM:
    - On each strobe, compare using the latched mode. The new sample replaces the best only if it is valid and either the best is invalid or the new value is strictly better. Ties keep the earlier sample.
    - cnt increments on valid samples.
    - The window counter increments on every strobe, valid or not.
  - Close:
    - On the strobe that makes the window counter equal the latched length, register the outputs and pulse out_strobe.
    - Return to IDLE.
    - A strobe on the following cycle starts a new window with no gap.
- **Mode and window length changes.**
  - mode is carried per sample through the tree, so a tree result always matches its own sample's mode.
  - Mode changes inside a window are legal. The accumulator still uses the window's latched mode.
  - win_len changes take effect at the next window start.
- **Clear and reset.**
  - sync_clr:
    - Clears all tree strobe/valid bits, the accumulator, and the counter; FSM goes to IDLE.
    - A strobe in the same cycle is discarded.
    - Outputs hold their last values; out_strobe is 0.
  - arst mid-window discards everything; no partial window is ever emitted.

## Timing
- Tree latency: L = LATENCY_UNIT × ceil(log2 CNO). With CNO=8 and LATENCY_UNIT=1, L=3.
- A strobe at input cycle t is seen by the accumulator at t+L.
- If that strobe closes a window, out_strobe and the outputs are valid at t+L+1.
- Full throughput: one strobe per cycle, no backpressure.
- Outputs are registered and change only on the cycle out_strobe is 1. They hold between windows.
- Reset values:
  - result, result_m, result_ch, result_cnt: 0
  - result_valid, out_strobe: 0
  - FSM: IDLE
  - all pipeline strobes: 0

## Test plan
Common setup: CNO=8, LATENCY_UNIT=1, L=3.

- **Reset.** Assert arst for 10 cycles with random inputs → all outputs 0, no out_strobe during reset or for 4 cycles after.
- **Single-sample min.**
  - Stimulus: win_len=1, mode=1, data={50,20,20,70,90,30,40,60}, all valid, m=0xA0+i, strobe at t.
  - Required at t+4: result=20, result_ch=1, result_m=0xA1, result_valid=1, result_cnt=1, out_strobe=1.
- **Windowed max with gaps.**
  - Stimulus: win_len=4, mode=0, four strobes at t, t+2, t+3, t+7. The third has 900 on ch5; the second has all channels invalid; the others have values ≤500.
  - Required: one out_strobe at t+11 with result=900, result_ch=5, result_cnt=3.
- **All-invalid window.** win_len=2, two strobes with valid_array=0 → out_strobe=1, result_valid=0, result=0, result_cnt=0.
- **Per-sample mode toggle.**
  - Stimulus: win_len=1, 10 back-to-back random strobes with mode alternating.
  - Required: 10 consecutive out_strobes, each matching the reference min/max of its own sample with the lowest-index tie rule.
- **Clear, reset, and zero length.**
  - Stimulus: win_len=3. Issue 2 strobes, then sync_clr (in the same cycle as a third strobe), then 3 new strobes. Repeat the sequence using arst instead of sync_clr.
  - Required: only the post-clear samples are reported.
  - Stimulus: win_len=0.
  - Required: behaves as win_len=1.

Source files
------------

// File: rtl/pipeline_minmax_window_core_if.sv
// Bundle for pipeline_minmax_window_core.
// Inputs (driven by master): per-channel data/metadata/valid, in_strobe, mode,
// win_len, sync_clr. Outputs (driven by slave): windowed winner result,
// result_m, result_ch, result_valid, result_cnt, out_strobe.
interface pipeline_minmax_window_core_if #(
  parameter int D_WIDTH = 26,
  parameter int M_WIDTH = 8,
  parameter int CNO     = 8,
  parameter int W_WIDTH = 8,
  parameter int CH_W    = $clog2(CNO)
);
  logic [CNO*D_WIDTH-1:0] data_array;
  logic [CNO*M_WIDTH-1:0] m_array;
  logic [CNO-1:0]         valid_array;
  logic                   in_strobe;
  logic                   mode;
  logic [W_WIDTH-1:0]     win_len;
  logic                   sync_clr;
  logic [D_WIDTH-1:0]     result;
  logic [M_WIDTH-1:0]     result_m;
  logic [CH_W-1:0]        result_ch;
  logic                   result_valid;
  logic [W_WIDTH-1:0]     result_cnt;
  logic                   out_strobe;

  modport master (
    output data_array, m_array, valid_array, in_strobe, mode, win_len, sync_clr,
    input  result, result_m, result_ch, result_valid, result_cnt, out_strobe
  );
  modport slave (
    input  data_array, m_array, valid_array, in_strobe, mode, win_len, sync_clr,
    output result, result_m, result_ch, result_valid, result_cnt, out_strobe
  );
endinterface

// File: rtl/pipeline_minmax_window_core.sv
// Pipelined min/max over CNO channels followed by accumulation across a
// window of win_len strobed samples. One winner (value, metadata, channel)
// and the count of samples with any valid channel are reported per window.
// Ports: clk, arst (async, active-high), bus (slave modport): see interface.
// Latency: strobe at t -> accumulator at t+L (L = LATENCY_UNIT*clog2(CNO)),
// closing window visible at t+L+1.
module pipeline_minmax_window_core #(
  parameter int D_WIDTH      = 26,
  parameter int M_WIDTH      = 8,
  parameter int CNO          = 8,
  parameter int LATENCY_UNIT = 1,
  parameter int W_WIDTH      = 8,
  parameter int CH_W         = $clog2(CNO)
) (
  input logic                            clk,
  input logic                            arst,
  pipeline_minmax_window_core_if.slave   bus
);
  localparam int NL = $clog2(CNO);

  typedef struct packed {
    logic               v;
    logic [CH_W-1:0]    ch;
    logic [M_WIDTH-1:0] m;
    logic [D_WIDTH-1:0] d;
  } node_t;

  function automatic int lvl_n(int l);
    return (CNO + (1 << l) - 1) >> l;
  endfunction

  function automatic int lvl_off(int l);
    int o = 0;
    for (int k = 0; k < l; k++) o += lvl_n(k);
    return o;
  endfunction

  localparam int TOT = lvl_off(NL + 1);

  // b beats a only if valid and strictly better; a is always the
  // lower-index (or earlier) operand, so ties fall to a. Invalid nodes
  // are kept all-zero, so returning an invalid a yields a zeroed node.
  function automatic node_t pick(node_t a, node_t b, logic md);
    logic better;
    better = md ? (b.d < a.d) : (b.d > a.d);
    if (b.v && (!a.v || better)) return b;
    return a;
  endfunction

  // All tree levels flattened into one array; level l occupies
  // [lvl_off(l) +: lvl_n(l)].
  node_t       nodes [TOT];
  logic [NL:0] stb_l, md_l;

  for (genvar i = 0; i < CNO; i++) begin : g_leaf
    assign nodes[i] = bus.valid_array[i] ?
      node_t'{v: 1'b1, ch: CH_W'(i), m: bus.m_array[i*M_WIDTH +: M_WIDTH],
              d: bus.data_array[i*D_WIDTH +: D_WIDTH]} : '0;
  end
  assign stb_l[0] = bus.in_strobe;
  assign md_l[0]  = bus.mode;

  for (genvar l = 1; l <= NL; l++) begin : g_lvl
    localparam int N  = lvl_n(l);
    localparam int NP = lvl_n(l - 1);
    localparam int PO = lvl_off(l - 1);
    localparam int OO = lvl_off(l);
    node_t                   cmb  [N];
    node_t                   pipe [LATENCY_UNIT][N];
    logic [LATENCY_UNIT-1:0] vld_pipe, md_pipe;

    for (genvar i = 0; i < N; i++) begin : g_node
      if (2*i + 1 < NP) begin : g_cmp
        assign cmb[i] = pick(nodes[PO+2*i], nodes[PO+2*i+1], md_l[l-1]);
      end else begin : g_pass
        assign cmb[i] = nodes[PO+2*i];
      end
      assign nodes[OO+i] = pipe[LATENCY_UNIT-1][i];
    end

    always_ff @(posedge clk or posedge arst) begin
      if (arst || bus.sync_clr) begin
        vld_pipe <= '0;
        md_pipe  <= '0;
        for (int s = 0; s < LATENCY_UNIT; s++)
          for (int i = 0; i < N; i++) pipe[s][i] <= '0;
      end else begin
        vld_pipe[0] <= stb_l[l-1];
        md_pipe[0]  <= md_l[l-1];
        for (int i = 0; i < N; i++) pipe[0][i] <= cmb[i];
        for (int s = 1; s < LATENCY_UNIT; s++) begin
          vld_pipe[s] <= vld_pipe[s-1];
          md_pipe[s]  <= md_pipe[s-1];
          for (int i = 0; i < N; i++) pipe[s][i] <= pipe[s-1][i];
        end
      end
    end
    assign stb_l[l] = vld_pipe[LATENCY_UNIT-1];
    assign md_l[l]  = md_pipe[LATENCY_UNIT-1];
  end

  // ---------------- window accumulator ----------------
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state, state_nx;

  node_t              t_node, best, base, nb, res;
  logic               t_stb, t_md, lmode, nmode, close, ostb;
  logic [W_WIDTH-1:0] len, len_in, nlen, wcnt, nwcnt, cnt, base_cnt, nb_cnt, res_cnt;

  assign t_node = nodes[lvl_off(NL)];
  assign t_stb  = stb_l[NL];
  assign t_md   = md_l[NL];
  assign len_in = (bus.win_len == '0) ? W_WIDTH'(1) : bus.win_len;

  always_ff @(posedge clk or posedge arst) begin
    if (arst)              state <= IDLE;
    else if (bus.sync_clr) state <= IDLE;
    else                   state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (t_stb && !close) state_nx = ACCUM;
      ACCUM:   if (close)           state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // In IDLE the incoming sample starts a fresh window against an empty
  // (invalid) best, using its own mode and the current win_len.
  always_comb begin
    base     = '0;
    base_cnt = '0;
    nmode    = t_md;
    nlen     = len_in;
    nwcnt    = W_WIDTH'(1);
    if (state == ACCUM) begin
      base     = best;
      base_cnt = cnt;
      nmode    = lmode;
      nlen     = len;
      nwcnt    = wcnt + W_WIDTH'(1);
    end
    nb     = pick(base, t_node, nmode);
    nb_cnt = base_cnt + W_WIDTH'(t_node.v);
    close  = t_stb && (nwcnt == nlen);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      best <= '0; cnt <= '0; wcnt <= '0; len <= '0; lmode <= 1'b0;
      res  <= '0; res_cnt <= '0; ostb <= 1'b0;
    end else if (bus.sync_clr) begin
      // results hold; only in-flight window state is dropped
      best <= '0; cnt <= '0; wcnt <= '0; ostb <= 1'b0;
    end else begin
      ostb <= close;
      if (t_stb) begin
        best  <= nb;
        cnt   <= nb_cnt;
        wcnt  <= nwcnt;
        len   <= nlen;
        lmode <= nmode;
      end
      if (close) begin
        res     <= nb;
        res_cnt <= nb_cnt;
      end
    end
  end

  assign bus.result       = res.d;
  assign bus.result_m     = res.m;
  assign bus.result_ch    = res.ch;
  assign bus.result_valid = res.v;
  assign bus.result_cnt   = res_cnt;
  assign bus.out_strobe   = ostb;
endmodule
